shift_right_seq: RTL and testbench
==================================

// Module: shift_right_seq
// PURPOSE
//  Multi-cycle right shifter/rotator for the ALU shift path. It is the right-direction
//  counterpart of the left barrel-shift stages.
//  Applies one power-of-two stage (8,4,2,1) per clock, under valid/ready handshakes on
//  both sides. Ops: logical shift right, arithmetic shift right, rotate right.
//  Sits between operand decode and the ALU result mux. Used when the shift needs a
//  fixed multi-cycle latency.
// PARAMETERS
//  WIDTH  16  data width; must be a power of two
//  CNT_W  4   shift-amount width; equals log2(WIDTH)
// PORTS
//  clk        in   1        single clock; all state changes on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        request present
//  in_ready   out  1        block can accept a request (high only in IDLE)
//  in_data    in   WIDTH    operand
//  in_cnt     in   CNT_W    shift amount, 0..WIDTH-1
//  in_op      in   2        00=SRL, 01=SRA, 10=ROR, 11=reserved (executes as SRL)
//  out_valid  out  1        result present
//  out_ready  in   1        consumer takes result
//  out_data   out  WIDTH    result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=0 while rst_n=0, out_valid=0,
//    out_data=0, internal stage index=CNT_W-1.
//  - States:
//    - IDLE: in_ready=1. On in_valid&&in_ready, latch data, cnt, op; go to SHIFT with
//      idx=CNT_W-1.
//    - SHIFT: each cycle, if cnt[idx] then data <= stage(data, 1<<idx, op). Then idx
//      decrements. Leave for DONE after idx=0 is processed.
//    - DONE: out_valid=1, out_data=result. On out_ready, go to IDLE, out_valid=0.
//  - Latency: fixed CNT_W cycles from the accept edge to out_valid, for every cnt
//    (cnt=0 included). No early exit.
//  - Throughput: one request per CNT_W+2 cycles minimum; no overlap. in_ready=0 in
//    SHIFT and DONE.
//  - Stage fill rules:
//    - SRL: vacated MSBs get 0.
//    - SRA: vacated MSBs get the operand MSB. Sign bit is taken from the latched
//      operand, stable across stages.
//    - ROR: vacated MSBs get the bits shifted out of the LSBs.
//  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
//    Inputs are ignored outside IDLE.
//  - in_valid and out_ready both high in DONE: only the result completes. The new
//    request is accepted next cycle, in IDLE.
//  - Reset mid-operation aborts immediately. The pending result is discarded; no
//    out_valid pulse follows.
//  - in_cnt is used modulo WIDTH by construction (CNT_W bits); no saturation.
// STRUCTURE
//  - Shared package shift_pkg: op encodings (OP_SRL, OP_SRA, OP_ROR), state enum
//    (S_IDLE, S_SHIFT, S_DONE), WIDTH/CNT_W defaults.
//  - Sub-module shift_right_stage: combinational, one stage.
//    - Ports: in[WIDTH], op, dist (param), en -> out.
//    - Instanced once. Distance is muxed by idx, or all four are instanced and
//      selected by idx.
//  - Top: FSM, idx counter, latched op/cnt/sign, data register.
// TESTING
//  1. SRL 0x8001 cnt=1 -> out_data=0x4000; out_valid exactly 4 cycles after accept.
//  2. SRA 0x8000 cnt=15 -> 0xFFFF. SRA 0x7F00 cnt=8 -> 0x007F.
//  3. ROR 0x1234 cnt=4 -> 0x4123. ROR 0x0001 cnt=15 -> 0x0002.
//  4. cnt=0, any op, data 0xA5A5 -> 0xA5A5 after the same 4-cycle latency;
//     op=11 cnt=4 on 0xF000 -> 0x0F00.
//  5. Backpressure: hold out_ready=0 for 3 cycles after out_valid. out_data stays
//     stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle.
//  6. Drop rst_n during SHIFT (idx=2) -> out_valid=0, out_data=0 at once. After
//     release, a new SRL 0x00F0 cnt=4 gives 0x000F.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared encodings and default sizes for the right shifter/rotator.
package shift_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;
  typedef enum logic [1:0] {OP_SRL = 2'b00, OP_SRA = 2'b01, OP_ROR = 2'b10} op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
endpackage

// File: rtl/shift_right_stage.sv
// shift_right_stage: one combinational right shift/rotate stage of distance dist_i.
module shift_right_stage import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic [CNT_W-1:0] dist_i,
  input  logic             en_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);
  logic [WIDTH-1:0] srl, fill, ror, shifted;
  assign srl = data_i >> dist_i;
  assign fill = ~({WIDTH{1'b1}} >> dist_i);
  assign ror = srl | (data_i << (WIDTH - int'(dist_i)));
  // Reserved op code falls through to a logical shift.
  assign shifted = (op_i == OP_SRA) ? (srl | (fill & {WIDTH{sign_i}})) :
                   (op_i == OP_ROR) ? ror : srl;
  assign data_o = en_i ? shifted : data_i;
endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: fixed-latency right shifter/rotator, one power-of-two stage per clock.
module shift_right_seq import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d, stage_out;
  logic [1:0] op_q, op_d;
  logic sign_q, sign_d;

  shift_right_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage (
    .data_i (data_q),
    .op_i   (op_q),
    .dist_i (CNT_W'(1) << idx_q),
    .en_i   (cnt_q[idx_q]),
    .sign_i (sign_q),
    .data_o (stage_out)
  );

  assign in_ready = rst_n && (state_q == S_IDLE);
  assign out_valid = state_q == S_DONE;
  assign out_data = data_q;

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    data_d = data_q;
    op_d = op_q;
    sign_d = sign_q;
    case (state_q)
      S_IDLE: if (in_valid && in_ready) begin
        state_d = S_SHIFT;
        idx_d = CNT_W'(CNT_W - 1);
        cnt_d = in_cnt;
        data_d = in_data;
        op_d = in_op;
        sign_d = in_data[WIDTH-1];
      end
      S_SHIFT: begin
        data_d = stage_out;
        idx_d = (idx_q == '0) ? CNT_W'(CNT_W - 1) : idx_q - 1'b1;
        state_d = (idx_q == '0) ? S_DONE : S_SHIFT;
      end
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= CNT_W'(CNT_W - 1);
      cnt_q <= '0;
      data_q <= '0;
      op_q <= '0;
      sign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      op_q <= op_d;
      sign_q <= sign_d;
    end
  end
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: vector table plus handshake, backpressure and reset sequences.
module tb_shift_right_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_data = '0;
  logic [3:0] in_cnt = '0;
  logic [1:0] in_op = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_data;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[13];

  shift_right_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c);
    logic [31:0] dd;
    dd = {d, d} >> c;
    if (op == 2'b01) return 16'($signed(d) >>> c);
    if (op == 2'b10) return dd[15:0];
    return d >> c;
  endfunction

  // Present a request at a negedge and return at the negedge after the accepting edge.
  task automatic drive_accept(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c, input logic [15:0] exp);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_op = op;
    in_data = d;
    in_cnt = c;
    @(posedge clk);
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int lat = 0;
    logic [15:0] first, e;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data = 16'hDEAD;
      in_cnt = 4'd1;
      in_op = 2'b00;
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_stable", out_data, first);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
    check("result", out_data, e);
    @(negedge clk);
    out_ready = 1'b0;
    check("done_clear", out_valid, 0);
    check("idle_ready", in_ready, 1);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 16'h8001, 4'd1,  16'h4000};
    vecs[1]  = '{2'b01, 16'h8000, 4'd15, 16'hFFFF};
    vecs[2]  = '{2'b01, 16'h7F00, 4'd8,  16'h007F};
    vecs[3]  = '{2'b10, 16'h1234, 4'd4,  16'h4123};
    vecs[4]  = '{2'b10, 16'h0001, 4'd15, 16'h0002};
    vecs[5]  = '{2'b00, 16'hA5A5, 4'd0,  16'hA5A5};
    vecs[6]  = '{2'b01, 16'hA5A5, 4'd0,  16'hA5A5};
    vecs[7]  = '{2'b10, 16'hA5A5, 4'd0,  16'hA5A5};
    vecs[8]  = '{2'b11, 16'hF000, 4'd4,  16'h0F00};
    vecs[9]  = '{2'b01, 16'hF0F0, 4'd4,  16'hFF0F};
    vecs[10] = '{2'b10, 16'h8001, 4'd1,  16'hC000};
    vecs[11] = '{2'b00, 16'hFFFF, 4'd15, 16'h0001};
    vecs[12] = '{2'b01, 16'h8001, 4'd3,  16'hF000};

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_accept(vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].exp);
      collect(0);
    end

    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [15:0] d;
      logic [3:0] c;
      op = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      c = 4'($urandom);
      drive_accept(op, d, c, model(op, d, c));
      collect(0);
    end

    // Backpressure, then result handshake with a new request already pending.
    drive_accept(2'b10, 16'h1234, 4'd4, 16'h4123);
    collect(3);
    drive_accept(2'b01, 16'h8000, 4'd1, 16'hC000);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    in_valid = 1'b1;
    in_op = 2'b00;
    in_data = 16'h00F0;
    in_cnt = 4'd4;
    out_ready = 1'b1;
    check("both_high_result", out_data, exp_q.size() > 0 ? exp_q.pop_front() : 16'hXXXX);
    check("both_high_no_accept", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("both_high_idle", in_ready, 1);
    check("both_high_no_valid", out_valid, 0);
    @(posedge clk);
    exp_q.push_back(16'h000F);
    @(negedge clk);
    in_valid = 1'b0;
    collect(0);

    // Abort mid-shift with idx=2.
    drive_accept(2'b00, 16'hFFFF, 4'd3, 16'h1FFF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_pulse", out_valid, 0);
    end
    drive_accept(2'b00, 16'h00F0, 4'd4, 16'h000F);
    collect(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
